// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store unit.
//   - SZ_BYTE / SZ_HALF / SZ_WORD : request size encodings (2'b11 is illegal)
//   - state_t                     : FSM state encoding, also exported for debug
//   - MEM_BYTES_DEFAULT           : default data memory size in bytes
package mem_access_pkg;

    localparam int MEM_BYTES_DEFAULT = 1024;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational data alignment for a big-endian 4-byte memory window.
// The addressed byte always sits in rdata[31:24].
//   size       in  request size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   sign_ext   in  sign-extend byte/halfword loads
//   wdata      in  right-justified store data
//   rdata      in  memory word read at the request address
//   load_data  out extracted and extended load result
//   merge_data out word to write back for a store (word store passes wdata)
module mem_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    always_comb begin
        load_data  = rdata;
        merge_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{sign_ext & rdata[31]}}, rdata[31:24]};
                merge_data = {wdata[7:0], rdata[23:0]};
            end
            SZ_HALF: begin
                load_data  = {{16{sign_ext & rdata[31]}}, rdata[31:16]};
                merge_data = {wdata[15:0], rdata[15:0]};
            end
            default: begin
                load_data  = rdata;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit in front of a byte-addressed big-endian memory.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and a requester
// must hold its request until it sees req_ready. resp_valid is a one-cycle
// pulse with no backpressure.
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_we/size/signed/addr/wdata  request fields
//   resp_valid/rdata/err     completion pulse and result
//   mem_addr/wdata/wr        memory pins (memory commits on falling edge)
//   mem_rdata                combinational read word, byte at mem_addr in [31:24]
//   dbg_state                current FSM state
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Every access touches a full 4-byte window, so the last legal address
    // is MEM_BYTES-4 regardless of size.
    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    state_t      state, state_nxt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    // Holds the word-store data, the merged store word, or the load result.
    logic [31:0] data_q;

    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)                              req_err = 1'b1;
        if ((req_size == SZ_HALF) && req_addr[0])           req_err = 1'b1;
        if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
        if (req_addr > LAST_ADDR)                           req_err = 1'b1;
    end

    mem_align u_align (
        .size       (size_q),
        .sign_ext   (sgn_q),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nxt = ST_RESP;
                    else if (req_we && (req_size == SZ_WORD))
                        state_nxt = ST_WRITE;
                    else
                        state_nxt = ST_READ;
                end
            end
            ST_READ:  state_nxt = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        sgn_q   <= req_signed;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        data_q  <= req_wdata;
                    end
                end
                ST_READ: data_q <= we_q ? merge_data : load_data;
                default: ;
            endcase
        end
    end

    // All outputs decode from registered state only, so no req_* input
    // reaches the memory pins combinationally and reset drops mem_wr at once.
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = (state == ST_RESP) && err_q;
    assign resp_rdata = ((state == ST_RESP) && !we_q && !err_q) ? data_q : 32'd0;
    assign mem_wr     = (state == ST_WRITE);
    assign mem_addr   = ((state == ST_READ) || (state == ST_WRITE)) ? addr_q : 32'd0;
    assign mem_wdata  = (state == ST_WRITE) ? data_q : 32'd0;
    assign dbg_state  = state;

endmodule
